filter_pad_sequencer: RTL and testbench
=======================================

Name: filter_pad_sequencer

Overview:
Sequences the raster RGB stream from the demosaic stage into the KxK spatial filter. It wraps each frame with zero borders of B=(KERNEL_SIZE-1)/2 pixels on every side, then drives flush beats to drain the filter pipeline. It replaces ad-hoc skip/boundary counters with one FSM. Upstream is throttled with a ready signal. Downstream, the filter has no backpressure.

Parameters:
WIDTH, 1920, active pixels per row
HEIGHT, 1080, active rows per frame
KERNEL_SIZE, 7, filter kernel size; must be odd and >=3
DATA_W, 24, packed pixel width {R,G,B}
FLUSH_CYCLES, 5786, zero beats emitted after the padded frame to drain the filter (default B*(WIDTH+2B)+8)

Ports:
clk  in  1  clock
reset  in  1  synchronous, active-high
iStart  in  1  frame start pulse; honoured only in IDLE
iValid  in  1  upstream pixel valid
iData  in  DATA_W  upstream pixel
iReady  out  1  upstream may transfer (combinational = state==ROW_DATA)
oValid  out  1  beat valid to filter (registered)
oData  out  DATA_W  beat data; zero on pad/flush beats (registered)
oSof  out  1  high with first beat of frame
oFlush  out  1  high on flush beats
oBusy  out  1  state != IDLE
oDone  out  1  1-cycle pulse after last flush beat
oStallCnt  out  32  ROW_DATA cycles with iValid=0 (see optional feature)

Behaviour:
- Reset: state IDLE; all outputs and counters 0; iReady=0.
- Counters: col (0..WIDTH+2B-1), row (0..HEIGHT+2B-1), flush (0..FLUSH_CYCLES-1). All 32-bit unsigned.
- FSM and transitions:
  - IDLE: iStart -> TOP_PAD, or ROW_LPAD if B=0 is disallowed, so always TOP_PAD.
  - TOP_PAD: emit a zero beat every cycle, B rows of WIDTH+2B beats -> ROW_LPAD.
  - ROW_LPAD: B zero beats -> ROW_DATA.
  - ROW_DATA: a beat is transferred only when iValid&&iReady. oData=iData, and col advances. A cycle with iValid=0 gives oValid=0 next cycle and no advance. After WIDTH transfers -> ROW_RPAD.
  - ROW_RPAD: B zero beats. If row was the last active row -> BOT_PAD, else -> ROW_LPAD.
  - BOT_PAD: B rows of zero beats -> FLUSH, or DONE if FLUSH_CYCLES=0.
  - FLUSH: FLUSH_CYCLES zero beats with oFlush=1 -> DONE.
  - DONE: oDone=1 for one cycle, oValid=0 -> IDLE.
- Latency: 1 cycle from the transfer/pad decision to oValid/oData.
- Padded beats per frame = (HEIGHT+2B)*(WIDTH+2B); data beats = WIDTH*HEIGHT.
- oSof is asserted with the first TOP_PAD beat only.
- iStart while oBusy is ignored. iStart in the same cycle as oDone is ignored; it is accepted the following cycle.
- iValid outside ROW_DATA is not consumed; upstream holds its data.
- Reset mid-frame: the frame is abandoned, IDLE next cycle, no oDone.

Optional Feature:
STALL_CNT_EN:
- Defined: oStallCnt counts ROW_DATA cycles with iValid=0. It clears on iStart acceptance, saturates at 2^32-1, and holds after DONE.
- Undefined: oStallCnt is tied to 0 and no counter logic is built.

Decomposition:
- Package isp_pkg holds:
  - state enum (IDLE, TOP_PAD, ROW_LPAD, ROW_DATA, ROW_RPAD, BOT_PAD, FLUSH, DONE);
  - constant function pad_width(k)=(k-1)/2;
  - PIX_W=24.
- One sub-module, isp_pos_counter: a parameterised col/row counter with wrap and last-col/last-row flags, plus an enable. The FSM stays in the top.

Test Plan:
- WIDTH=8, HEIGHT=4, K=3, FLUSH=5; iValid held 1; iStart pulse:
  - 60 padded beats then 5 flush beats;
  - beats 0-9 zero;
  - beat 11 = pixel 0;
  - 32 data beats total;
  - oDone exactly 1 cycle after the 65th beat.
- Same config with iValid toggling 1,0 during data: each 0 gives an oValid gap; data order is intact; oStallCnt=32 with STALL_CNT_EN.
- iValid=1 during TOP_PAD/ROW_RPAD: iReady=0, and no pixel is consumed or lost.
- iStart pulsed mid-frame (cycle 20): ignored, and the beat count is still 65.
- reset at beat 30: IDLE next cycle; oValid=0, oBusy=0, no oDone. A new iStart then produces a full correct frame.
- K=7, WIDTH=4, HEIGHT=2: B=3; 80 padded beats; each data row is 3 zeros, 4 pixels, 3 zeros.

Source files
------------

// File: rtl/isp_pkg.sv
// Shared ISP types: the pad-sequencer state encoding, the border-width helper and
// the packed RGB pixel width.
package isp_pkg;

   localparam int PIX_W = 24;

   typedef enum logic [2:0] {
      IDLE,
      TOP_PAD,
      ROW_LPAD,
      ROW_DATA,
      ROW_RPAD,
      BOT_PAD,
      FLUSH,
      DONE
   } seq_state_e;

   // Zero border on each side of the frame for an odd KxK kernel.
   function automatic int pad_width(input int k);
      return (k - 1) / 2;
   endfunction

endpackage

// File: rtl/isp_pos_counter.sv
// Raster position counter over a COLS x ROWS grid. It wraps at the end of each
// row and at the end of the frame, and flags the last column and the last row.
module isp_pos_counter #(
   parameter int COLS = 10,
   parameter int ROWS = 6
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        clr_i,
   input  logic        en_i,
   output logic [31:0] col_o,
   output logic [31:0] row_o,
   output logic        last_col_o,
   output logic        last_row_o
);

   logic [31:0] col_q, col_d;
   logic [31:0] row_q, row_d;

   assign last_col_o = (col_q == 32'(COLS - 1));
   assign last_row_o = (row_q == 32'(ROWS - 1));
   assign col_o      = col_q;
   assign row_o      = row_q;

   // NOTE: every always_comb output is given a default first, so no path can infer a latch.
   always_comb begin
      col_d = col_q;
      row_d = row_q;
      if (clr_i) begin
         col_d = '0;
         row_d = '0;
      end else if (en_i) begin
         if (last_col_o) begin
            col_d = '0;
            row_d = last_row_o ? '0 : row_q + 32'd1;
         end else begin
            col_d = col_q + 32'd1;
         end
      end
   end

   // NOTE: registers take non-blocking assignments, so every flop samples pre-edge values.
   always_ff @(posedge clk) begin
      if (reset) begin
         col_q <= '0;
         row_q <= '0;
      end else begin
         col_q <= col_d;
         row_q <= row_d;
      end
   end

endmodule

// File: rtl/filter_pad_sequencer.sv
// Wraps each raster frame in a zero border for the KxK filter, then sends flush beats.
// Optional macro STALL_CNT_EN builds the counter of upstream stall cycles.
module filter_pad_sequencer
   import isp_pkg::*;
#(
   parameter int WIDTH        = 1920,
   parameter int HEIGHT       = 1080,
   parameter int KERNEL_SIZE  = 7,
   parameter int DATA_W       = PIX_W,
   parameter int FLUSH_CYCLES = 5786
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              iStart,
   input  logic              iValid,
   input  logic [DATA_W-1:0] iData,
   output logic              iReady,
   output logic              oValid,
   output logic [DATA_W-1:0] oData,
   output logic              oSof,
   output logic              oFlush,
   output logic              oBusy,
   output logic              oDone,
   output logic [31:0]       oStallCnt
);

   localparam int B  = pad_width(KERNEL_SIZE);
   localparam int PW = WIDTH + 2 * B;
   localparam int PH = HEIGHT + 2 * B;

   seq_state_e        state_q, state_d;
   logic [31:0]       flush_q, flush_d;
   logic              valid_q, sof_q, flush_beat_q, done_q;
   logic [DATA_W-1:0] data_q;

   logic [31:0] col, row;
   logic        last_col, last_row;
   logic        start_acc, beat, pass_data, sof, flush_beat, cnt_en;

   // The cycle in which oDone shows is still blocked, so a start lands only after it.
   assign start_acc = (state_q == IDLE) && iStart && !done_q;

   isp_pos_counter #(
      .COLS(PW),
      .ROWS(PH)
   ) u_pos (
      .clk       (clk),
      .reset     (reset),
      .clr_i     (start_acc),
      .en_i      (cnt_en),
      .col_o     (col),
      .row_o     (row),
      .last_col_o(last_col),
      .last_row_o(last_row)
   );

   always_comb begin
      state_d    = state_q;
      flush_d    = flush_q;
      beat       = 1'b0;
      pass_data  = 1'b0;
      sof        = 1'b0;
      flush_beat = 1'b0;
      cnt_en     = 1'b0;
      unique case (state_q)
         IDLE: begin
            flush_d = '0;
            if (start_acc) state_d = TOP_PAD;
         end
         TOP_PAD: begin
            beat   = 1'b1;
            cnt_en = 1'b1;
            sof    = (col == '0) && (row == '0);
            if (last_col && row == 32'(B - 1)) state_d = ROW_LPAD;
         end
         ROW_LPAD: begin
            beat   = 1'b1;
            cnt_en = 1'b1;
            if (col == 32'(B - 1)) state_d = ROW_DATA;
         end
         ROW_DATA: begin
            if (iValid) begin
               beat      = 1'b1;
               pass_data = 1'b1;
               cnt_en    = 1'b1;
               if (col == 32'(B + WIDTH - 1)) state_d = ROW_RPAD;
            end
         end
         ROW_RPAD: begin
            beat   = 1'b1;
            cnt_en = 1'b1;
            if (last_col) state_d = (row == 32'(B + HEIGHT - 1)) ? BOT_PAD : ROW_LPAD;
         end
         BOT_PAD: begin
            beat   = 1'b1;
            cnt_en = 1'b1;
            if (last_col && last_row) state_d = (FLUSH_CYCLES == 0) ? DONE : FLUSH;
         end
         FLUSH: begin
            beat       = 1'b1;
            flush_beat = 1'b1;
            flush_d    = flush_q + 32'd1;
            if (flush_q == 32'(FLUSH_CYCLES - 1)) state_d = DONE;
         end
         DONE:    state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q      <= IDLE;
         flush_q      <= '0;
         valid_q      <= 1'b0;
         data_q       <= '0;
         sof_q        <= 1'b0;
         flush_beat_q <= 1'b0;
         done_q       <= 1'b0;
      end else begin
         state_q      <= state_d;
         flush_q      <= flush_d;
         valid_q      <= beat;
         data_q       <= pass_data ? iData : '0;
         sof_q        <= sof;
         flush_beat_q <= flush_beat;
         done_q       <= (state_q == DONE);
      end
   end

   assign iReady = (state_q == ROW_DATA);
   assign oBusy  = (state_q != IDLE);
   assign oValid = valid_q;
   assign oData  = data_q;
   assign oSof   = sof_q;
   assign oFlush = flush_beat_q;
   assign oDone  = done_q;

`ifdef STALL_CNT_EN
   logic [31:0] stall_q;

   always_ff @(posedge clk) begin
      if (reset) begin
         stall_q <= '0;
      end else if (start_acc) begin
         stall_q <= '0;
      end else if (state_q == ROW_DATA && !iValid && stall_q != '1) begin
         stall_q <= stall_q + 32'd1;
      end
   end

   assign oStallCnt = stall_q;
`else
   assign oStallCnt = '0;
`endif

endmodule

// File: tb/tb_filter_pad_sequencer.sv
// Directed bench for filter_pad_sequencer: K=3 and K=7 frames, upstream stalls, ignored
// starts and a mid-frame reset, all checked against a padded-raster reference model.
module tb_filter_pad_sequencer;

   logic        clk = 1'b0;
   logic        reset = 1'b1;
   logic        iStart = 1'b0;
   logic        iValid = 1'b0;
   logic [23:0] iData = '0;
   bit          sel = 1'b0;

   logic        start3, rdy3, v3, sof3, fl3, busy3, done3;
   logic        start7, rdy7, v7, sof7, fl7, busy7, done7;
   logic [23:0] d3, d7;
   logic [31:0] st3, st7;

   assign start3 = iStart && !sel;
   assign start7 = iStart && sel;

   filter_pad_sequencer #(
      .WIDTH(8), .HEIGHT(4), .KERNEL_SIZE(3), .DATA_W(24), .FLUSH_CYCLES(5)
   ) dut3 (
      .clk(clk), .reset(reset), .iStart(start3), .iValid(iValid), .iData(iData),
      .iReady(rdy3), .oValid(v3), .oData(d3), .oSof(sof3), .oFlush(fl3),
      .oBusy(busy3), .oDone(done3), .oStallCnt(st3)
   );

   filter_pad_sequencer #(
      .WIDTH(4), .HEIGHT(2), .KERNEL_SIZE(7), .DATA_W(24), .FLUSH_CYCLES(4)
   ) dut7 (
      .clk(clk), .reset(reset), .iStart(start7), .iValid(iValid), .iData(iData),
      .iReady(rdy7), .oValid(v7), .oData(d7), .oSof(sof7), .oFlush(fl7),
      .oBusy(busy7), .oDone(done7), .oStallCnt(st7)
   );

   always #5 clk = ~clk;

   logic        m_ready, m_valid, m_sof, m_flush, m_busy, m_done;
   logic [23:0] m_data;
   logic [31:0] m_stall;
   assign m_ready = sel ? rdy7  : rdy3;
   assign m_valid = sel ? v7    : v3;
   assign m_sof   = sel ? sof7  : sof3;
   assign m_flush = sel ? fl7   : fl3;
   assign m_busy  = sel ? busy7 : busy3;
   assign m_done  = sel ? done7 : done3;
   assign m_data  = sel ? d7    : d3;
   assign m_stall = sel ? st7   : st3;

`ifdef STALL_CNT_EN
   localparam bit STALL_ON = 1'b1;
`else
   localparam bit STALL_ON = 1'b0;
`endif

   int n_checks = 0;
   int n_errors = 0;

   int W, H, B, F, PW, PH, tot;
   int idx, cyc, first_ready, first_beat, last_beat, done_cnt, done_cyc, ready_cnt;
   bit gap, gap_mode, did_xfer, did_idle;
   logic [25:0] beats[$];

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
      end
   endtask

   function automatic logic [23:0] pix(input int n);
      return 24'h5A0000 + 24'(n);
   endfunction

   // Reference beat i as {sof, flush, data}: padded raster first, then flush beats.
   function automatic logic [25:0] exp_beat(input int i);
      int r, c;
      if (i >= PH * PW) return {1'b0, 1'b1, 24'h0};
      r = i / PW;
      c = i % PW;
      if (r >= B && r < B + H && c >= B && c < B + W) return {2'b00, pix((r - B) * W + c - B)};
      return {(i == 0), 1'b0, 24'h0};
   endfunction

   task automatic set_cfg(input bit s);
      sel = s;
      if (!s) begin W = 8; H = 4; B = 1; F = 5; end
      else    begin W = 4; H = 2; B = 3; F = 4; end
      PW  = W + 2 * B;
      PH  = H + 2 * B;
      tot = W * H;
   endtask

   // One clock: update the upstream model for the last handshake, then sample outputs.
   task automatic step();
      @(negedge clk);
      if (did_xfer) begin
         idx++;
         gap = 1'b1;
      end else if (did_idle) begin
         gap = 1'b0;
      end
      iValid   = (idx < tot) && !(gap_mode && gap);
      iData    = pix(idx);
      did_xfer = iValid && m_ready;
      did_idle = !iValid && m_ready && gap_mode && gap;
      cyc++;
      if (m_ready) begin
         ready_cnt++;
         if (first_ready < 0) first_ready = cyc;
      end
      if (m_valid) begin
         beats.push_back({m_sof, m_flush, m_data});
         if (first_beat < 0) first_beat = cyc;
         last_beat = cyc;
      end
      if (m_done) begin
         done_cnt++;
         if (done_cyc < 0) done_cyc = cyc;
      end
   endtask

   task automatic begin_frame(input bit gaps);
      idx = 0; gap = 1'b1; gap_mode = gaps; did_xfer = 1'b0; did_idle = 1'b0;
      cyc = 0; first_ready = -1; first_beat = -1; last_beat = -1;
      done_cnt = 0; done_cyc = -1; ready_cnt = 0;
      beats.delete();
   endtask

   task automatic run_frame(input bit gaps, input bit mid_start, input bit start_at_done);
      int nb;
      iStart = 1'b1;
      if (!start_at_done) iStart = 1'b0;
      step();
      check("done_pulse_width", m_done, 1'b0);
      if (start_at_done) check("start_at_done_ignored", m_busy, 1'b0);
      begin_frame(gaps);
      iStart = 1'b1;
      step();
      check("start_accepted", m_busy, 1'b1);
      for (int n = 0; n < 3000 && done_cnt == 0; n++) begin
         iStart = mid_start && (cyc == 20);
         step();
      end
      iStart = 1'b0;
      nb = PH * PW + F;
      check("beat_count", beats.size(), nb);
      for (int i = 0; i < beats.size() && i < nb; i++)
         check($sformatf("beat%0d", i), beats[i], exp_beat(i));
      check("done_once", done_cnt, 1);
      check("done_after_last", done_cyc, last_beat + 1);
      check("gap_cycles", (last_beat - first_beat + 1) - beats.size(), gaps ? W * H : 0);
      check("ready_cycles", ready_cnt, gaps ? 2 * W * H : W * H);
      check("first_ready", first_ready, 1 + B * PW + B);
      check("consumed", idx, W * H);
      check("stall_cnt", m_stall, (STALL_ON && gaps) ? W * H : 0);
      check("busy_at_done", m_busy, 1'b0);
   endtask

   initial begin
      set_cfg(1'b0);
      begin_frame(1'b0);
      repeat (3) step();
      reset = 1'b0;
      step();
      check("rst_outputs", {m_valid, m_sof, m_flush, m_busy, m_done, m_ready, m_data}, '0);
      check("rst_stall", m_stall, 0);

      run_frame(1'b0, 1'b0, 1'b0);
      run_frame(1'b1, 1'b0, 1'b1);
      run_frame(1'b0, 1'b1, 1'b0);

      // Abandon a frame with reset once 30 beats are out.
      step();
      begin_frame(1'b0);
      iStart = 1'b1;
      step();
      iStart = 1'b0;
      for (int n = 0; n < 500 && beats.size() < 30; n++) step();
      check("rst_mid_reached", beats.size(), 30);
      reset = 1'b1;
      step();
      reset = 1'b0;
      check("rst_mid_valid", m_valid, 1'b0);
      check("rst_mid_busy", m_busy, 1'b0);
      check("rst_mid_ready", m_ready, 1'b0);
      done_cnt = 0;
      beats.delete();
      repeat (100) step();
      check("rst_mid_no_done", done_cnt, 0);
      check("rst_mid_no_beats", beats.size(), 0);
      run_frame(1'b0, 1'b0, 1'b0);

      set_cfg(1'b1);
      run_frame(1'b0, 1'b0, 1'b0);

      $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
      $finish;
   end

endmodule
